vecmac_stream: RTL
==================

Name: vecmac_stream

Overview:
- Streaming, parametrised dot-product engine: the next generation of the fixed-size vector multiplier.
- Accepts vectors of any length as a sequence of LANES-wide beats over a valid/ready handshake, with per-lane masking.
- Multiplies lane pairs, reduces them with a registered adder tree and accumulates across beats. One result is emitted per vector, on an output valid/ready handshake, with beat count and overflow flag.
- Sits between the operand fetch buffers and the result writeback path.

Parameters:
DATA_W, 16, operand width per lane
LANES, 4, lanes per beat (any value >= 1; adder tree is padded to the next power of two with zeros)
ACC_W, 40, accumulator/result width (must be >= 2*DATA_W + clog2(LANES))
SIGNED, 1, 1 = two's-complement operands and accumulator; 0 = unsigned

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of all in-flight state
in_valid  input  1  beat valid
in_ready  output  1  beat accepted when in_valid && in_ready
in_a  input  LANES*DATA_W  lane i operand A at [i*DATA_W +: DATA_W]
in_b  input  LANES*DATA_W  lane i operand B, same packing
in_mask  input  LANES  1 = lane contributes; 0 = lane product forced to 0
in_last  input  1  final beat of the current vector
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid && out_ready
out_data  output  ACC_W  dot-product result
out_beats  output  16  beats in the vector, saturating at 65535
out_ovf  output  1  accumulator overflowed at least once during the vector
busy  output  1  any beat in flight or partial accumulation nonzero

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All pipeline valids, the accumulator, beat count and overflow flag go to 0.
  - out_valid=0, out_data=0, out_beats=0, out_ovf=0, busy=0.
  - in_ready=1 from the first cycle after reset release.
- Pipeline (advances only when adv=1):
  - S1 registers LANES products. Masked lanes give 0.
  - Products are full 2*DATA_W, sign-extended when SIGNED=1 and zero-extended otherwise.
  - S2 registers the adder-tree sum, extended to ACC_W.
  - S3 is the accumulator/result stage.
- Stall: adv = !(s2_valid && s2_last && out_valid && !out_ready).
  - in_ready = adv && !clear.
  - When adv=0, S1/S2 hold their contents and no beat is accepted.
- Accumulate, on S2 valid and adv:
  - Non-last beat: acc <= acc + sum; beat count increments, saturating.
  - Last beat: out_data <= acc + sum; out_beats <= count+1 (saturating); out_ovf <= ovf_sticky | ovf_this_beat; out_valid <= 1.
  - On a last beat, acc, count and sticky ovf are all cleared in the same cycle.
- Latency: a last beat accepted in cycle T gives out_valid=1 in cycle T+3 when there is no stall.
  - Back-to-back single-beat vectors sustain one result per cycle while out_ready=1.
- Output: out_data, out_beats and out_ovf hold stable while out_valid && !out_ready.
  - out_valid drops the cycle after the handshake unless a new result loads in that same cycle. In that case out_valid stays 1 with the new data.
- Overflow:
  - SIGNED=1: the signed ACC_W addition overflows (operand signs equal, result sign differs).
  - SIGNED=0: carry out of bit ACC_W-1.
  - The sum wraps modulo 2^ACC_W. The flag is sticky until the vector completes.
- Empty masks: a beat with in_mask=0 still counts toward out_beats and contributes 0.
- Clear:
  - Drops S1/S2 valid and zeroes acc, count, sticky ovf and out_valid.
  - A beat presented during clear is not accepted (in_ready=0).
  - out_data/out_beats/out_ovf values are don't-care once out_valid=0.
- Reset mid-vector: everything is discarded. The next accepted beat starts a new vector.
- busy = s1_valid | s2_valid | (count != 0).

Test Plan:
- Single beat a={1,2,3,4}, b={5,6,7,8}, mask=4'hF, last=1 accepted at T -> out_valid at T+3, out_data=70, out_beats=1, out_ovf=0.
- Three beats: a={1,1,1,1}/b={2,2,2,2}; a={3,0,0,0}/b={3,9,9,9} with mask=4'b0001; a={-1,-1,-1,-1}/b={1,1,1,1} with last -> out_data=13, out_beats=3, busy=0 after the result.
- Signed extremes: a=b=-32768 on all lanes, single beat -> out_data=4294967296, out_ovf=0. Same operands with SIGNED=0 and 16'h8000 -> same value.
- Backpressure: out_ready=0, then two single-beat vectors (results 70 and 10) -> first result holds. The second vector reaches S2 and then in_ready=0. Releasing out_ready gives 70 then 10 on consecutive cycles with no beat loss.
- Overflow: 200 beats of a=b=-32768 on all lanes, last on beat 200 -> out_ovf=1, out_beats=200, out_data = -240518168576 (wrapped mod 2^40).
- Clear asserted after beat 2 of a vector, then a fresh single-beat vector (result 70) -> out_data=70, out_beats=1. Repeat using rst_n low mid-vector -> same outcome, all outputs 0 during reset.

Source files
------------

// File: rtl/vecmac_stream.sv
// vecmac_stream: streaming masked dot-product engine; accumulates LANES-wide beats per vector
// and emits one result with beat count and sticky overflow per vector.
module vecmac_stream #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int ACC_W  = 40,
    parameter int SIGNED = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    input  logic [LANES-1:0]        in_mask,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [15:0]             out_beats,
    output logic                    out_ovf,
    output logic                    busy
);
    localparam int PW = 2 * DATA_W;
    localparam bit SG = (SIGNED != 0);

    function automatic logic [PW-1:0] mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea = SG ? PW'($signed(a)) : PW'(a);
        eb = SG ? PW'($signed(b)) : PW'(b);
        return ea * eb;
    endfunction

    function automatic logic [ACC_W-1:0] ext(input logic [PW-1:0] p);
        return SG ? ACC_W'($signed(p)) : ACC_W'(p);
    endfunction

    logic [PW-1:0]    prod    [LANES];
    logic [PW-1:0]    s1_prod [LANES];
    logic             s1_valid, s1_last, s2_valid, s2_last, ovf_sticky, ovf_beat, adv;
    logic [ACC_W-1:0] lane_sum, s2_sum, acc;
    logic [ACC_W:0]   acc_nxt;
    logic [15:0]      cnt, cnt_nxt;

    always_comb begin
        for (int i = 0; i < LANES; i++)
            prod[i] = in_mask[i] ? mul(in_a[i*DATA_W +: DATA_W], in_b[i*DATA_W +: DATA_W]) : '0;
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum = lane_sum + ext(s1_prod[i]);
    end

    // The pipeline only stalls when a finished result is waiting behind an unconsumed one.
    assign adv      = !(s2_valid && s2_last && out_valid && !out_ready);
    assign in_ready = adv && !clear;
    assign acc_nxt  = {1'b0, acc} + {1'b0, s2_sum};
    assign ovf_beat = SG ? (acc[ACC_W-1] == s2_sum[ACC_W-1]) && (acc_nxt[ACC_W-1] != acc[ACC_W-1])
                         : acc_nxt[ACC_W];
    assign cnt_nxt  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign busy     = s1_valid | s2_valid | (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            s2_sum     <= '0;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_beats  <= '0;
            out_ovf    <= 1'b0;
            for (int i = 0; i < LANES; i++)
                s1_prod[i] <= '0;
        end else if (clear) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (adv) begin
                s1_valid <= in_valid;
                s1_last  <= in_last;
                for (int i = 0; i < LANES; i++)
                    s1_prod[i] <= prod[i];
                s2_valid <= s1_valid;
                s2_last  <= s1_last;
                s2_sum   <= lane_sum;
            end
            if (adv && s2_valid && s2_last) begin
                out_valid  <= 1'b1;
                out_data   <= acc_nxt[ACC_W-1:0];
                out_beats  <= cnt_nxt;
                out_ovf    <= ovf_sticky | ovf_beat;
                acc        <= '0;
                cnt        <= '0;
                ovf_sticky <= 1'b0;
            end else begin
                if (out_ready)
                    out_valid <= 1'b0;
                if (adv && s2_valid) begin
                    acc        <= acc_nxt[ACC_W-1:0];
                    cnt        <= cnt_nxt;
                    ovf_sticky <= ovf_sticky | ovf_beat;
                end
            end
        end
    end
endmodule
